mmio_decoder: RTL and testbench
===============================

// Module: mmio_decoder
// PURPOSE
//  Host-side MMIO address decoder and transaction sequencer that sits directly upstream of the
//  MMIO peripherals (timer, UART, GPIO, ...). Splits a fixed address window into equal slots.
//  Drives one-hot per-slot selects and registered address/data/strobes, and waits for the
//  selected slot's ready. Returns one registered response to the CPU memory bus.
//  Guards against hung or absent peripherals with a bounded-wait timeout.
// PARAMETERS
//  NUM_SLAVES      4              number of peripheral slots (1..16)
//  BASE_ADDR       32'h8000_0000  window base; must be aligned to 2**(SLOT_BITS+4)
//  SLOT_BITS       8              log2 bytes per slot; slot index = addr[SLOT_BITS+3:SLOT_BITS]
//  TIMEOUT_CYCLES  255            max ACCESS cycles before forced error completion (>=1)
//  ERR_RDATA       32'hDEAD_BEEF  read data returned on decode error or timeout
// PORTS
//  clk_i        in   1            single system clock
//  rst_i        in   1            synchronous, active-high reset
//  mem_valid_i  in   1            CPU request; held with addr/wdata/wstrb until mem_ready_o
//  mem_addr_i   in   32           CPU byte address
//  mem_wdata_i  in   32           CPU write data
//  mem_wstrb_i  in   4            byte write strobes; 0 = read
//  mem_ready_o  out  1            one-cycle completion pulse
//  mem_rdata_o  out  32           response data, valid while mem_ready_o=1
//  sel_o        out  NUM_SLAVES   one-hot slot select; high only in ACCESS
//  slv_addr_o   out  32           registered request address
//  slv_wdata_o  out  32           registered write data
//  slv_wstrb_o  out  4            registered strobes; forced 0 outside ACCESS
//  slv_ready_i  in   NUM_SLAVES   per-slot ready (may be combinational from sel_o)
//  slv_rdata_i  in   32*NUM_SLAVES per-slot read data, slot k at [32k+31:32k]
//  err_o        out  1            one-cycle pulse with mem_ready_o on decode error or timeout
// BEHAVIOUR
//  Reset: state=IDLE. sel_o, slv_wstrb_o, mem_ready_o and err_o = 0.
//   slv_addr_o, slv_wdata_o, mem_rdata_o = 0. Timeout count = 0. Reset mid-transaction aborts it
//   with no completion.
//  FSM IDLE -> ACCESS | RESP -> IDLE:
//  - IDLE: on mem_valid_i=1, latch addr/wdata/wstrb and compute slot index.
//    Hit (in window, index<NUM_SLAVES): go to ACCESS.
//    Miss: rdata<=ERR_RDATA and flag error; go to RESP.
//  - ACCESS: sel_o[idx]=1, strobes driven, timeout count increments each cycle.
//    If slv_ready_i[idx]=1, capture slv_rdata_i[idx]; go to RESP.
//    Else if count==TIMEOUT_CYCLES-1, rdata<=ERR_RDATA and flag error; go to RESP.
//  - RESP: mem_ready_o=1 for exactly one cycle; err_o=1 if error flagged; go to IDLE.
//    All selects and strobes are 0. The count is cleared.
//  Latency: a single-cycle slave completes with mem_ready_o in the 3rd cycle after mem_valid_i
//   is sampled. Back-to-back requests have one IDLE cycle between them.
//  Ready and timeout in the same cycle: ready wins, with normal data and no error.
//  Ready bits of non-selected slots are ignored. Requests arriving in ACCESS or RESP are ignored.
//   The host holds mem_valid_i until ready.
//  Writes: mem_rdata_o carries whatever the slot returned; the CPU ignores it.
//  Count width: $clog2(TIMEOUT_CYCLES+1). The count never wraps.
// CONFIGURATION
//  MMIO_TIMEOUT_EN defined: timeout logic as above.
//  MMIO_TIMEOUT_EN undefined: no counter. ACCESS waits indefinitely for ready.
//   err_o pulses only on a decode miss.
// TESTING
//  Read slot1 at 0x8000_0104, slave ready same cycle as sel, rdata 0x1234_5678 ->
//   sel_o=4'b0010 for 1 cycle; mem_ready_o in cycle 3 with 0x1234_5678; err_o=0.
//  Write 0x0000_0003 with wstrb 4'hF to 0x8000_0000 -> slv_wstrb_o=4'hF and slv_wdata_o=3
//   only during the single ACCESS cycle; strobes 0 otherwise.
//  Read 0x8000_0500 (slot 5 >= NUM_SLAVES) -> no sel_o; mem_ready_o in cycle 2 with
//   0xDEAD_BEEF; err_o=1.
//  Slot2 never ready, TIMEOUT_CYCLES=4 with MMIO_TIMEOUT_EN -> sel_o[2] high for 4 cycles;
//   then mem_ready_o with 0xDEAD_BEEF and err_o=1.
//  Slot2 ready on exactly the 4th ACCESS cycle -> normal data, err_o=0.
//  Assert rst_i during ACCESS -> next cycle sel_o=0, mem_ready_o=0, state IDLE;
//   a new request completes normally.

Source files
------------

// File: rtl/mmio_decoder.sv
// mmio_decoder: host-side MMIO address decoder and transaction sequencer.
// A fixed window at BASE_ADDR is split into NUM_SLAVES slots of 2**SLOT_BITS
// bytes each. An accepted request selects one slot and waits for its ready
// signal. The CPU then gets one registered response.
// Optional build macro: MMIO_TIMEOUT_EN. When it is defined, a bounded-wait
// counter forces an error completion after TIMEOUT_CYCLES ACCESS cycles.
// Without it, ACCESS waits indefinitely for the slot's ready.
module mmio_decoder #(
  parameter int          NUM_SLAVES     = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
  parameter int          SLOT_BITS      = 8,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     mem_valid_i,
  input  logic [31:0]              mem_addr_i,
  input  logic [31:0]              mem_wdata_i,
  input  logic [3:0]               mem_wstrb_i,
  output logic                     mem_ready_o,
  output logic [31:0]              mem_rdata_o,
  output logic [NUM_SLAVES-1:0]    sel_o,
  output logic [31:0]              slv_addr_o,
  output logic [31:0]              slv_wdata_o,
  output logic [3:0]               slv_wstrb_o,
  input  logic [NUM_SLAVES-1:0]    slv_ready_i,
  input  logic [32*NUM_SLAVES-1:0] slv_rdata_i,
  output logic                     err_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // The window spans 16 slot positions; bits above them form the window tag.
  localparam int TAG_LSB = SLOT_BITS + 4;

  // Parameter combinations the decoder cannot honour stop elaboration.
  if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 1 ||
      SLOT_BITS < 1 || SLOT_BITS > 27) begin : g_badParams
    $error("mmio_decoder: illegal parameter set");
  end

  logic [1:0]  r_state;
  logic [3:0]  r_idx;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [3:0]            w_reqIdx;
  logic                  w_inWindow;
  logic                  w_hit;
  logic                  w_slotReady;
  logic [31:0]           w_slotData;
  logic [NUM_SLAVES-1:0] w_sel;
  logic                  w_timeout;

  assign w_reqIdx   = mem_addr_i[SLOT_BITS+3:SLOT_BITS];
  assign w_inWindow = (mem_addr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign w_hit      = w_inWindow && ({1'b0, w_reqIdx} < 5'(NUM_SLAVES));

  // Pick the ready bit and read data of the latched slot; the other slots' ready bits are ignored.
  always_comb begin
    w_slotReady = 1'b0;
    w_slotData  = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (r_idx == 4'(k)) begin
        w_slotReady = slv_ready_i[k];
        w_slotData  = slv_rdata_i[32*k +: 32];
      end
    end
  end

  // One-hot slot select, asserted only while the access is in flight.
  always_comb begin
    w_sel = '0;
    if (r_state == ST_ACCESS) begin
      for (int k = 0; k < NUM_SLAVES; k++) begin
        if (r_idx == 4'(k)) begin
          w_sel[k] = 1'b1;
        end
      end
    end
  end

`ifdef MMIO_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_count;

  assign w_timeout = (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count ACCESS cycles and saturate so the count never wraps. Clear it whenever no access is in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (r_state == ST_ACCESS) begin
      if (r_count != CNT_W'(TIMEOUT_CYCLES)) begin
        r_count <= r_count + 1'b1;
      end
    end else begin
      r_count <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Transaction sequencer: latch the request in IDLE and wait for the slot in ACCESS. Hand back one response in RESP.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mem_valid_i) begin
            r_addr  <= mem_addr_i;
            r_wdata <= mem_wdata_i;
            r_wstrb <= mem_wstrb_i;
            r_idx   <= w_reqIdx;
            if (w_hit) begin
              r_err   <= 1'b0;
              r_state <= ST_ACCESS;
            end else begin
              r_rdata <= ERR_RDATA;
              r_err   <= 1'b1;
              r_state <= ST_RESP;
            end
          end
        end
        ST_ACCESS: begin
          if (w_slotReady) begin
            r_rdata <= w_slotData;
            r_err   <= 1'b0;
            r_state <= ST_RESP;
          end else if (w_timeout) begin
            r_rdata <= ERR_RDATA;
            r_err   <= 1'b1;
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign sel_o       = w_sel;
  assign slv_addr_o  = r_addr;
  assign slv_wdata_o = r_wdata;
  assign slv_wstrb_o = (r_state == ST_ACCESS) ? r_wstrb : 4'h0;
  assign mem_ready_o = (r_state == ST_RESP);
  assign err_o       = (r_state == ST_RESP) && r_err;
  assign mem_rdata_o = r_rdata;

endmodule

// File: tb/tb_mmio_decoder.sv
// tb_mmio_decoder: randomized self-checking bench for mmio_decoder.
// A behavioural slave per slot answers after a chosen number of ACCESS cycles.
// A request-level model predicts the following for every transaction:
// latency, select activity, response data and error.
// The timeout scenarios are built only when MMIO_TIMEOUT_EN is defined.
module tb_mmio_decoder;

  localparam int          NS    = 4;
  localparam int          TO    = 4;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          SLOTB = 256;
  localparam logic [31:0] ERRV  = 32'hDEAD_BEEF;
  localparam int          NEVER = 1000;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            mem_valid_i;
  logic [31:0]     mem_addr_i;
  logic [31:0]     mem_wdata_i;
  logic [3:0]      mem_wstrb_i;
  logic            mem_ready_o;
  logic [31:0]     mem_rdata_o;
  logic [NS-1:0]   sel_o;
  logic [31:0]     slv_addr_o;
  logic [31:0]     slv_wdata_o;
  logic [3:0]      slv_wstrb_o;
  logic [NS-1:0]   slv_ready_i;
  logic [32*NS-1:0] slv_rdata_i;
  logic            err_o;

  int          testsRun = 0;
  int          failures = 0;
  int          slotLat[NS];
  logic [31:0] slotData[NS];
  int          accCycles;

  mmio_decoder #(
    .NUM_SLAVES(NS),
    .BASE_ADDR(BASE),
    .SLOT_BITS(8),
    .TIMEOUT_CYCLES(TO),
    .ERR_RDATA(ERRV)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .mem_valid_i(mem_valid_i),
    .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i),
    .mem_wstrb_i(mem_wstrb_i),
    .mem_ready_o(mem_ready_o),
    .mem_rdata_o(mem_rdata_o),
    .sel_o(sel_o),
    .slv_addr_o(slv_addr_o),
    .slv_wdata_o(slv_wdata_o),
    .slv_wstrb_o(slv_wstrb_o),
    .slv_ready_i(slv_ready_i),
    .slv_rdata_i(slv_rdata_i),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Count how long the current slot has been selected.
  always @(posedge clk_i) begin
    if (rst_i || sel_o == '0) accCycles <= 0;
    else                      accCycles <= accCycles + 1;
  end

  // Each slave raises ready combinationally once it has been selected for slotLat cycles.
  always_comb begin
    slv_ready_i = '0;
    slv_rdata_i = '0;
    for (int k = 0; k < NS; k++) begin
      slv_ready_i[k] = sel_o[k] && (accCycles >= slotLat[k]);
      slv_rdata_i[32*k +: 32] = slotData[k];
    end
  end

  // Count one comparison and report it if it mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Run one host request and compare the whole transaction against the request-level model.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    longint      off;
    bit          hit;
    bit          timedOut;
    int          slot;
    int          expN;
    int          edges;
    int          selCycles;
    int          busBad;
    bit          done;
    logic [31:0] expData;
    logic [NS-1:0] oneHot;

    off  = longint'(addr) - longint'(BASE);
    hit  = (off >= 0) && (off < 16 * SLOTB) && ((off / SLOTB) < NS);
    slot = hit ? int'(off / SLOTB) : 0;
    timedOut = 1'b0;
    expN = 0;
    if (hit) begin
`ifdef MMIO_TIMEOUT_EN
      if (slotLat[slot] >= TO) begin
        timedOut = 1'b1;
        expN = TO;
      end else begin
        expN = slotLat[slot] + 1;
      end
`else
      expN = slotLat[slot] + 1;
`endif
    end
    expData = (!hit || timedOut) ? ERRV : slotData[slot];
    oneHot  = NS'(1 << slot);

    @(negedge clk_i);
    mem_valid_i = 1'b1;
    mem_addr_i  = addr;
    mem_wdata_i = wdata;
    mem_wstrb_i = wstrb;

    edges = 0; selCycles = 0; busBad = 0; done = 1'b0;
    while (!done && edges < 400) begin
      @(posedge clk_i);
      #1;
      edges++;
      if (mem_ready_o) begin
        done = 1'b1;
        if (sel_o != '0 || slv_wstrb_o != 4'h0) busBad++;
      end else if (sel_o != '0) begin
        selCycles++;
        if (sel_o != oneHot || slv_wstrb_o != wstrb || slv_addr_o != addr || slv_wdata_o != wdata)
          busBad++;
      end else if (slv_wstrb_o != 4'h0) begin
        busBad++;
      end
    end

    checkOutput("completed", 32'(done), 32'd1);
    if (done) begin
      checkOutput("latency", 32'(edges), 32'(hit ? expN + 1 : 1));
      checkOutput("rdata", mem_rdata_o, expData);
      checkOutput("err", 32'(err_o), 32'(!hit || timedOut));
      checkOutput("selCycles", 32'(selCycles), 32'(expN));
      checkOutput("slaveBus", 32'(busBad), 32'd0);
      mem_valid_i = 1'b0;
      @(posedge clk_i);
      #1;
      checkOutput("readyPulse", {30'd0, mem_ready_o, err_o}, 32'd0);
    end else begin
      mem_valid_i = 1'b0;
    end
  endtask

  function automatic int pickLatency();
    int choice;
    choice = int'($urandom_range(0, 7));
    case (choice)
      0: return 0;
      1: return 1;
      2: return 2;
      3: return 3;
      4: return 4;
      5: return 6;
      6: return 9;
`ifdef MMIO_TIMEOUT_EN
      default: return NEVER;
`else
      default: return 12;
`endif
    endcase
  endfunction

  initial begin
    logic [31:0] addr;
    logic [3:0]  strb;
    int          cat;

    rst_i = 1'b1;
    mem_valid_i = 1'b0;
    mem_addr_i = '0;
    mem_wdata_i = '0;
    mem_wstrb_i = '0;
    for (int k = 0; k < NS; k++) begin
      slotLat[k] = 0;
      slotData[k] = 32'h1000_0000 + 32'(k);
    end
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("rstSel", 32'(sel_o), 32'd0);
    checkOutput("rstReadyErr", {30'd0, mem_ready_o, err_o}, 32'd0);
    checkOutput("rstWstrb", 32'(slv_wstrb_o), 32'd0);
    checkOutput("rstAddr", slv_addr_o, 32'd0);
    checkOutput("rstWdata", slv_wdata_o, 32'd0);
    checkOutput("rstRdata", mem_rdata_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    slotData[1] = 32'h1234_5678;
    applyStimulus(32'h8000_0104, 32'h0, 4'h0);
    slotData[0] = 32'h0BAD_F00D;
    applyStimulus(32'h8000_0000, 32'h0000_0003, 4'hF);
    applyStimulus(32'h8000_0500, 32'h0, 4'h0);
    applyStimulus(32'h9000_0100, 32'h5555_AAAA, 4'h3);
    slotData[2] = 32'hCAFE_0002;
`ifdef MMIO_TIMEOUT_EN
    slotLat[2] = NEVER;
    applyStimulus(32'h8000_0208, 32'h0, 4'h0);
`else
    slotLat[2] = 9;
    applyStimulus(32'h8000_0208, 32'h0, 4'h0);
`endif
    slotLat[2] = TO - 1;
    applyStimulus(32'h8000_020C, 32'h0, 4'h0);
    slotLat[3] = 0;
    applyStimulus(32'h8000_03FC, 32'h7777_0000, 4'h1);

    slotLat[1] = NEVER;
    @(negedge clk_i);
    mem_valid_i = 1'b1;
    mem_addr_i  = 32'h8000_0100;
    mem_wdata_i = 32'h0000_00AA;
    mem_wstrb_i = 4'hF;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("midAccessSel", 32'(sel_o), 32'd2);
    @(negedge clk_i);
    rst_i = 1'b1;
    mem_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    checkOutput("abortSel", 32'(sel_o), 32'd0);
    checkOutput("abortReady", {30'd0, mem_ready_o, err_o}, 32'd0);
    checkOutput("abortWstrb", 32'(slv_wstrb_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    slotLat[1] = 1;
    slotData[1] = 32'h4242_4242;
    applyStimulus(32'h8000_0110, 32'h0, 4'h0);

    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < NS; k++) begin
        slotLat[k]  = pickLatency();
        slotData[k] = $urandom;
      end
      cat = int'($urandom_range(0, 3));
      case (cat)
        0, 1: addr = BASE + 32'($urandom_range(0, NS - 1)) * SLOTB + 32'($urandom_range(0, 63)) * 4;
        2:    addr = BASE + 32'($urandom_range(NS, 15)) * SLOTB + 32'($urandom_range(0, 255));
        default: addr = $urandom;
      endcase
      strb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      applyStimulus(addr, $urandom, strb);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

  // Stop a run that never completes, as a safety net.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
